// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and default operand width
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow for the serial datapath
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic d,
    output logic borrow_out
);
    assign d = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per cycle
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state, state_next;
    logic [WIDTH-1:0] sa, sb, res, res_next;
    logic [CW-1:0] cnt;
    logic borrow, d_bit, b_bit, last;

    full_subtractor u_fs (
        .a(sa[0]),
        .b(sb[0]),
        .borrow_in(borrow),
        .d(d_bit),
        .borrow_out(b_bit)
    );

    // New bit enters at the MSB so after WIDTH shifts bit i sits at position i
    assign res_next = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last = cnt == CW'(WIDTH - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        state_next = state;
        state_next = (state == IDLE && in_valid) ? RUN :
                     (state == RUN && last) ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
            res <= '0;
            cnt <= '0;
            borrow <= 1'b0;
            diff <= '0;
            borrow_out <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sa <= a;
            sb <= b;
            cnt <= '0;
            borrow <= 1'b0;
        end else if (state == RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            res <= res_next;
            cnt <= cnt + 1'b1;
            borrow <= b_bit;
            if (last) begin
                diff <= res_next;
                borrow_out <= b_bit;
            end
        end
    end
endmodule
